// File: rtl/calc_entry_if.sv
// Keypad-to-datapath bundle for the calculator entry controller.
// key_valid is a one-cycle strobe with no ready: the controller samples key_in on every edge where key_valid is high and never stalls the decoder.
interface calc_entry_if #(
    parameter int OPW = 14
);
    logic           key_valid;
    logic [3:0]     key_in;
    logic [1:0]     mode;
    logic [1:0]     operator;
    logic [OPW-1:0] operand_a;
    logic [OPW-1:0] operand_b;
    logic [3:0]     digit_cnt;
    logic           done;
    logic           key_reject;

    modport master (
        output key_valid, key_in,
        input  mode, operator, operand_a, operand_b, digit_cnt, done, key_reject
    );

    modport slave (
        input  key_valid, key_in,
        output mode, operator, operand_a, operand_b, digit_cnt, done, key_reject
    );
endinterface

// File: rtl/calc_entry_fsm.sv
// Keypad entry controller: builds two binary operands and an operator from decimal keys.
// The FSM state is the registered mode output, so it is directly observable.
module calc_entry_fsm #(
    parameter int DIGITS = 4,
    parameter int OPW    = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    calc_entry_if.slave  bus
);
    localparam logic [1:0] MODE_FIRST  = 2'd0;
    localparam logic [1:0] MODE_SECOND = 2'd1;
    localparam logic [1:0] MODE_ENTER  = 2'd2;

    localparam logic [3:0] KEY_ENTER = 4'd13;
    localparam logic [3:0] KEY_CLEAR = 4'd14;
    localparam logic [3:0] KEY_BKSP  = 4'd15;

    localparam logic [3:0]     MAX_CNT = 4'(DIGITS);
    localparam logic [OPW-1:0] TEN     = OPW'(10);

    logic [1:0]     mode_q, mode_d;
    logic [1:0]     operator_q, operator_d;
    logic [OPW-1:0] operand_a_q, operand_a_d;
    logic [OPW-1:0] operand_b_q, operand_b_d;
    logic [3:0]     cnt_a_q, cnt_a_d;
    logic [3:0]     cnt_b_q, cnt_b_d;
    logic [3:0]     digit_cnt_q, digit_cnt_d;
    logic           done_q, done_d;
    logic           key_reject_q, key_reject_d;

    logic           is_digit;
    logic           is_op;
    logic [1:0]     op_code;
    logic [OPW-1:0] digit_val;

    assign is_digit  = (bus.key_in <= 4'd9);
    assign is_op     = (bus.key_in >= 4'd10) && (bus.key_in <= 4'd12);
    assign op_code   = 2'(bus.key_in - 4'd10);
    assign digit_val = OPW'(bus.key_in);

    always_comb begin
        mode_d       = mode_q;
        operator_d   = operator_q;
        operand_a_d  = operand_a_q;
        operand_b_d  = operand_b_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        done_d       = 1'b0;
        key_reject_d = 1'b0;

        if (bus.key_valid) begin
            if (bus.key_in == KEY_CLEAR) begin
                mode_d      = MODE_FIRST;
                operator_d  = 2'd0;
                operand_a_d = '0;
                operand_b_d = '0;
                cnt_a_d     = 4'd0;
                cnt_b_d     = 4'd0;
            end else begin
                case (mode_q)
                    MODE_FIRST: begin
                        if (is_digit) begin
                            if (cnt_a_q < MAX_CNT) begin
                                operand_a_d = operand_a_q * TEN + digit_val;
                                cnt_a_d     = cnt_a_q + 4'd1;
                            end else begin
                                key_reject_d = 1'b1;
                            end
                        end else if (is_op) begin
                            operator_d  = op_code;
                            operand_b_d = '0;
                            cnt_b_d     = 4'd0;
                            mode_d      = MODE_SECOND;
                        end else if (bus.key_in == KEY_BKSP && cnt_a_q != 4'd0) begin
                            operand_a_d = operand_a_q / TEN;
                            cnt_a_d     = cnt_a_q - 4'd1;
                        end else begin
                            key_reject_d = 1'b1;
                        end
                    end
                    MODE_SECOND: begin
                        if (is_digit) begin
                            if (cnt_b_q < MAX_CNT) begin
                                operand_b_d = operand_b_q * TEN + digit_val;
                                cnt_b_d     = cnt_b_q + 4'd1;
                            end else begin
                                key_reject_d = 1'b1;
                            end
                        end else if (is_op) begin
                            if (cnt_b_q == 4'd0) operator_d = op_code;
                            else                 key_reject_d = 1'b1;
                        end else if (bus.key_in == KEY_BKSP) begin
                            // Backspacing past an empty second operand reopens the first one.
                            if (cnt_b_q != 4'd0) begin
                                operand_b_d = operand_b_q / TEN;
                                cnt_b_d     = cnt_b_q - 4'd1;
                            end else begin
                                mode_d = MODE_FIRST;
                            end
                        end else if (bus.key_in == KEY_ENTER) begin
                            mode_d = MODE_ENTER;
                            done_d = 1'b1;
                        end
                    end
                    MODE_ENTER: begin
                        if (is_digit) begin
                            mode_d      = MODE_FIRST;
                            operator_d  = 2'd0;
                            operand_a_d = digit_val;
                            operand_b_d = '0;
                            cnt_a_d     = 4'd1;
                            cnt_b_d     = 4'd0;
                        end else begin
                            key_reject_d = 1'b1;
                        end
                    end
                    default: mode_d = MODE_FIRST;
                endcase
            end
        end
    end

    always_comb begin
        case (mode_d)
            MODE_FIRST:  digit_cnt_d = cnt_a_d;
            MODE_SECOND: digit_cnt_d = cnt_b_d;
            default:     digit_cnt_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_FIRST;
            operator_q   <= 2'd0;
            operand_a_q  <= '0;
            operand_b_q  <= '0;
            cnt_a_q      <= 4'd0;
            cnt_b_q      <= 4'd0;
            digit_cnt_q  <= 4'd0;
            done_q       <= 1'b0;
            key_reject_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            operator_q   <= operator_d;
            operand_a_q  <= operand_a_d;
            operand_b_q  <= operand_b_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            digit_cnt_q  <= digit_cnt_d;
            done_q       <= done_d;
            key_reject_q <= key_reject_d;
        end
    end

    assign bus.mode       = mode_q;
    assign bus.operator   = operator_q;
    assign bus.operand_a  = operand_a_q;
    assign bus.operand_b  = operand_b_q;
    assign bus.digit_cnt  = digit_cnt_q;
    assign bus.done       = done_q;
    assign bus.key_reject = key_reject_q;
endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed bench for calc_entry_fsm: key sequences with hand-computed expected operands and pulses.
module tb_calc_entry_fsm;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    calc_entry_if #(.OPW(14)) bus ();

    calc_entry_fsm #(.DIGITS(4), .OPW(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Strobe one key for a single edge; returns at the following negedge with outputs settled.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_in    = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int m, input int op, input int a, input int b, input int dc);
        chk({tag, ".mode"},      32'(bus.mode),      32'(m));
        chk({tag, ".operator"},  32'(bus.operator),  32'(op));
        chk({tag, ".operand_a"}, 32'(bus.operand_a), 32'(a));
        chk({tag, ".operand_b"}, 32'(bus.operand_b), 32'(b));
        chk({tag, ".digit_cnt"}, 32'(bus.digit_cnt), 32'(dc));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_in    = 4'd0;
        repeat (3) @(negedge clk);
        chk_state("reset", 0, 0, 0, 0, 0);
        chk("reset.done", 32'(bus.done), 0);
        chk("reset.reject", 32'(bus.key_reject), 0);
        rst_n = 1'b1;

        // Basic calculation 12 + 34 enter
        press(4'd1); press(4'd2);
        chk_state("a12", 0, 0, 12, 0, 2);
        press(4'd10);
        chk_state("op_add", 1, 0, 12, 0, 0);
        press(4'd3); press(4'd4);
        chk("b34.done", 32'(bus.done), 0);
        press(4'd13);
        chk_state("enter", 2, 0, 12, 34, 0);
        chk("enter.done", 32'(bus.done), 1);
        @(negedge clk);
        chk("enter.done_drop", 32'(bus.done), 0);

        // Digit limit
        press(4'd14);
        for (int i = 0; i < 4; i++) begin
            press(4'd9);
            chk("lim.reject_low", 32'(bus.key_reject), 0);
        end
        press(4'd9);
        chk("lim.reject_5th", 32'(bus.key_reject), 1);
        chk_state("lim", 0, 0, 9999, 0, 4);
        @(negedge clk);
        chk("lim.reject_drop", 32'(bus.key_reject), 0);

        // Backspace through second operand back into the first
        press(4'd14);
        press(4'd13);
        chk("first_enter.reject", 32'(bus.key_reject), 1);
        press(4'd5); press(4'd6); press(4'd11);
        chk_state("bs_op", 1, 1, 56, 0, 0);
        press(4'd7);
        chk_state("bs_b7", 1, 1, 56, 7, 1);
        press(4'd15);
        chk_state("bs1", 1, 1, 56, 0, 0);
        press(4'd15);
        chk_state("bs2", 0, 1, 56, 0, 2);
        chk("bs2.reject", 32'(bus.key_reject), 0);
        press(4'd15);
        chk_state("bs3", 0, 1, 5, 0, 1);
        press(4'd15);
        press(4'd15);
        chk("bs_empty.reject", 32'(bus.key_reject), 1);
        chk_state("bs_empty", 0, 1, 0, 0, 0);

        // Clear mid-second-operand, then idle strobe-less key toggling
        press(4'd4); press(4'd12); press(4'd8);
        chk_state("pre_clr", 1, 2, 4, 8, 1);
        press(4'd14);
        chk_state("clr", 0, 0, 0, 0, 0);
        chk("clr.reject", 32'(bus.key_reject), 0);
        press(4'd6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.key_in = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        chk_state("idle", 0, 0, 6, 0, 1);
        chk("idle.reject", 32'(bus.key_reject), 0);

        // ENTER state: rejects then a digit restarts
        press(4'd14);
        press(4'd3); press(4'd10); press(4'd13);
        chk_state("ent", 2, 0, 3, 0, 0);
        press(4'd10);
        chk("ent_op.reject", 32'(bus.key_reject), 1);
        chk_state("ent_op", 2, 0, 3, 0, 0);
        press(4'd15);
        chk("ent_bs.reject", 32'(bus.key_reject), 1);
        press(4'd13);
        chk("ent_ent.reject", 32'(bus.key_reject), 1);
        chk("ent_ent.done", 32'(bus.done), 0);
        press(4'd7);
        chk_state("restart", 0, 0, 7, 0, 1);
        chk("restart.reject", 32'(bus.key_reject), 0);

        // Operator replacement only while second operand is empty
        press(4'd14);
        press(4'd2); press(4'd11); press(4'd12);
        chk_state("oprep", 1, 2, 2, 0, 0);
        chk("oprep.reject", 32'(bus.key_reject), 0);
        press(4'd5); press(4'd10);
        chk("oplate.reject", 32'(bus.key_reject), 1);
        chk_state("oplate", 1, 2, 2, 5, 1);
        press(4'd13);
        chk_state("b_enter", 2, 2, 2, 5, 0);
        chk("b_enter.done", 32'(bus.done), 1);

        // Asynchronous reset mid-SECOND with a strobe pending
        press(4'd14);
        press(4'd8); press(4'd10); press(4'd6);
        chk_state("pre_rst", 1, 0, 8, 6, 1);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_in    = 4'd9;
        #2 rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.key_valid = 1'b0;
        chk_state("rst_hold", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        press(4'd4); press(4'd2);
        chk_state("post_rst", 0, 0, 42, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Parametrised keypad entry controller for the calculator datapath.
- Sits between the debounced keypad decoder and the ALU/display logic.
- Sequences the entry of first operand, operator, second operand and enter.
- Accumulates decimal digits into binary operands; supports backspace, clear and digit-limit checking; all outputs are registered.

Parameters:
DIGITS, 4, maximum decimal digits per operand (1..9)
OPW, 14, operand width in bits; must satisfy 2^OPW > 10^DIGITS-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  one-cycle strobe; key_in is sampled only when high
key_in  input  4  key code: 0-9 digit, 10 add, 11 sub, 12 mul, 13 enter, 14 clear, 15 backspace
mode  output  2  0 FIRST, 1 SECOND, 2 ENTER (3 never driven)
operator  output  2  0 add, 1 sub, 2 mul
operand_a  output  OPW  first operand, binary
operand_b  output  OPW  second operand, binary
digit_cnt  output  4  digits held in the operand currently being edited (0 in ENTER)
done  output  1  one-cycle pulse on entry to ENTER
key_reject  output  1  one-cycle pulse when an accepted strobe is ignored

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state and outputs are registered.
- Reset values: mode=0, operator=0, operand_a=0, operand_b=0, digit_cnt=0, done=0, key_reject=0. Internal cnt_a=cnt_b=0.
- Latency: the effect of a strobe sampled at edge N is visible after edge N. With key_valid=0, all registers hold and done/key_reject are 0.
- done and key_reject are 0 on every cycle except the single cycle that follows their triggering strobe.
- Internal per-operand digit counters cnt_a and cnt_b. digit_cnt mirrors cnt_a in FIRST, cnt_b in SECOND, and is 0 in ENTER.
- Clear (14), any state: go to FIRST; operands, counters and operator return to 0; no reject.
- FIRST state:
  - Digit d: if cnt_a<DIGITS, operand_a <= operand_a*10+d and cnt_a++; else key_reject.
  - Operator (10/11/12): operator <= key-10; cnt_b=0; operand_b=0; go to SECOND. Allowed with cnt_a=0 (operand_a=0).
  - Backspace: if cnt_a>0, operand_a <= operand_a/10 and cnt_a--; else key_reject.
  - Enter: key_reject.
- SECOND state:
  - Digit: same as FIRST, applied to operand_b/cnt_b.
  - Operator: if cnt_b=0, replace operator and stay in SECOND; else key_reject.
  - Backspace: if cnt_b>0, operand_b/10 and cnt_b--. If cnt_b=0, return to FIRST; operand_a and cnt_a are kept, operator is unchanged.
  - Enter: go to ENTER and pulse done. Allowed with cnt_b=0 (operand_b=0).
- ENTER state:
  - Outputs hold for the result stage.
  - Digit d: start a new calculation. operand_a=d, cnt_a=1, operand_b=0, cnt_b=0, operator=0, go to FIRST.
  - Operator, enter, backspace: key_reject; nothing else changes.
- Arithmetic: *10 and /10 are unsigned, truncating, OPW bits wide. Overflow cannot occur when the parameter constraint holds.
- Reset mid-entry: asynchronous return to reset values on the same assertion, regardless of key_valid.
- key_in values outside an action's legal set follow the rules above; no X propagation is permitted.

Test Plan:
- Reset, then strobes 1,2,10,3,4,13 -> operand_a=12, operator=0, operand_b=34, mode=2; done high exactly one cycle after the 13 strobe.
- DIGITS=4: strobes 9,9,9,9,9 -> operand_a=9999, digit_cnt=4; key_reject on the 5th strobe only.
- Strobes 5,6,11,7,15,15,15 -> after the 2nd backspace mode=0, operand_a=56, digit_cnt=2, operator=1; the 3rd backspace gives operand_a=5.
- Strobes 4,12,8,14 -> all operands and operator 0, mode=0, no key_reject; key_in toggling with key_valid=0 -> no change.
- Strobes 3,10,13 to reach ENTER, then 10 -> key_reject; then 7 -> mode=0, operand_a=7, operand_b=0, operator=0.
- Assert rst_n low mid-SECOND between clock edges -> outputs reach reset values immediately; operand entry resumes normally after release.
